// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The arbiter state encoding and the requester-count bound live here so the
// arbiter and any monitor or debug logic agree on them.
package uart_pkg;

  // Largest number of requesters the round-robin picker is built for.
  localparam int NUM_REQ_MAX = 8;

  // Narrowest launch-timeout counter that is ever generated.
  localparam int TMO_CNT_MIN_W = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

  // Width of a counter that can reach (timeout - 1), never below TMO_CNT_MIN_W.
  function automatic int tmo_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w > TMO_CNT_MIN_W) ? w : TMO_CNT_MIN_W;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Requests at or above ptr_i are preferred, lowest index first. If none of
// them are set, the search wraps to the lowest set request below ptr_i.
// A requester that has just won sits below the advanced pointer, so every
// other requester is searched before it becomes eligible again.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] cand;
  logic               found;

  // Rotating-mask priority: mask off requests below the pointer, fall back to
  // the unmasked vector when the masked one is empty, then take the lowest bit.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    masked   = '0;
    cand     = '0;
    found    = 1'b0;
    winner_o = '0;
    idx_o    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req_i[i] && (IDX_W'(i) >= ptr_i);
    end
    cand = (|masked) ? masked : req_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand[i] && !found) begin
        found       = 1'b1;
        winner_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers. One frame is in flight at a time: the winner's byte and parity
// flag are latched, send_request is held until the UART reports tx_busy, and
// the winner gets a grant pulse at launch and a done pulse at completion.
//
// Optional feature, macro UART_ARB_TIMEOUT_EN: abort a launch that the UART
// has not acknowledged with tx_busy within LAUNCH_TIMEOUT cycles, pulse done
// for the owner and raise the sticky timeout_err flag. Without the macro the
// launch waits indefinitely and timeout_err is tied low.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int LAUNCH_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_parity,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           send_request,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           parity_enable,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic                           arb_busy,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Elaboration-time guard on the supported parameter range.
  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || LAUNCH_TIMEOUT < 1) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and LAUNCH_TIMEOUT at least 1");
  end

  arb_state_t           state_q;
  logic [IDX_W-1:0]     ptr_q;          // search start: last winner + 1
  logic [NUM_REQ-1:0]   owner_q;        // one-hot owner of the current frame
  logic                 send_request_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 parity_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 arb_busy_q;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [IDX_W-1:0]     ptr_d;
  logic [DATA_BITS-1:0] sel_data;
  logic                 sel_parity;
  logic                 launch_ok;
  logic                 tmo_hit;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Byte and parity flag of the current winner.
  always_comb begin
    sel_data   = '0;
    sel_parity = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        sel_data   = req_data[i*DATA_BITS +: DATA_BITS];
        sel_parity = req_parity[i];
      end
    end
  end

  // Next search start after a launch, wrapping modulo NUM_REQ.
  assign ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // Only start a frame while the UART is fully quiet.
  assign launch_ok = pick_valid && !tx_busy && !tx_done;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_width(LAUNCH_TIMEOUT);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;

  // Fires in the LAUNCH_TIMEOUT-th LAUNCH cycle that still has no tx_busy.
  assign tmo_hit = (state_q == LAUNCH) && !tx_busy &&
                   (tmo_cnt_q == CNT_W'(LAUNCH_TIMEOUT - 1));

  // Launch cycle counter, cleared outside LAUNCH; sticky abort flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == LAUNCH) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
      if (tmo_hit) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbiter FSM with registered outputs, data latch and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      send_request_q <= 1'b0;
      tx_data_q      <= '0;
      parity_q       <= 1'b0;
      grant_q        <= '0;
      done_q         <= '0;
      arb_busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here is
      // updated from the pre-edge values and the later defaults-then-override
      // ordering behaves like a priority mux.
      grant_q <= '0;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          if (launch_ok) begin
            tx_data_q      <= sel_data;
            parity_q       <= sel_parity;
            owner_q        <= pick_onehot;
            ptr_q          <= ptr_d;
            grant_q        <= pick_onehot;
            send_request_q <= 1'b1;
            arb_busy_q     <= 1'b1;
            state_q        <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (tx_busy) begin
            send_request_q <= 1'b0;
            state_q        <= WAIT_DONE;
          end else if (tmo_hit) begin
            send_request_q <= 1'b0;
            done_q         <= owner_q;
            state_q        <= RELEASE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            done_q  <= owner_q;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          // A tx_done held high for several cycles must not end a second frame.
          if (!tx_busy && !tx_done) begin
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          send_request_q <= 1'b0;
          arb_busy_q     <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign send_request  = send_request_q;
  assign tx_data       = tx_data_q;
  assign parity_enable = parity_q;
  assign arb_busy      = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. A small behavioural UART answers
// send_request with a busy window of FRAME cycles followed by a one-cycle
// tx_done, and records the byte and parity flag it was handed.
// Build with +define+UART_ARB_TIMEOUT_EN to also exercise the launch timeout.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_BITS = 8;
  localparam int TIMEOUT   = 64;
  localparam int FRAME     = 4;
  // Grant-to-grant spacing with FRAME=4: 1 LAUNCH + 4 WAIT_DONE + 1 RELEASE + 1 IDLE.
  localparam int GAP       = 7;

  logic                         clk;
  logic                         reset_n;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_parity;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic                         send_request;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         parity_enable;
  logic                         tx_busy;
  logic                         tx_done;
  logic                         arb_busy;
  logic                         timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // UART model state
  bit   uart_en = 1'b1;
  int   m_cnt;
  logic [7:0] m_data;
  logic m_par;
  int   m_unstable = 0;
  logic [7:0] rx_q[$];
  logic       rxp_q[$];

  // Tracker results
  int   g_q[$];
  int   gcyc_q[$];
  logic [7:0] gdata_q[$];
  int   d_q[$];
  int   sr_cycles;
  int   bad_grant;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_BITS      (DATA_BITS),
    .LAUNCH_TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_data      (req_data),
    .req_parity    (req_parity),
    .grant         (grant),
    .done          (done),
    .send_request  (send_request),
    .tx_data       (tx_data),
    .parity_enable (parity_enable),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .arb_busy      (arb_busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural UART, acting 2 time units after each rising edge.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    m_cnt   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!uart_en) begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        m_cnt   = 0;
      end else if (tx_done) begin
        tx_done = 1'b0;
      end else if (tx_busy) begin
        if (tx_data !== m_data || parity_enable !== m_par) m_unstable++;
        m_cnt++;
        if (m_cnt == FRAME) begin
          tx_busy = 1'b0;
          tx_done = 1'b1;
          rx_q.push_back(m_data);
          rxp_q.push_back(m_par);
        end
      end else if (send_request === 1'b1) begin
        tx_busy = 1'b1;
        m_cnt   = 0;
        m_data  = tx_data;
        m_par   = parity_enable;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] pack_idx(input int q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) r = (r << 4) | 32'(q[i] + 1);
    return r;
  endfunction

  function automatic logic [31:0] pack_bytes(input logic [7:0] q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) r = (r << 8) | 32'(q[i]);
    return r;
  endfunction

  task automatic clear_logs();
    g_q.delete(); gcyc_q.delete(); gdata_q.delete(); d_q.delete();
    rx_q.delete(); rxp_q.delete();
    sr_cycles = 0; bad_grant = 0; m_unstable = 0;
  endtask

  // Runs until n_done done pulses have been seen and the arbiter is idle.
  // Requesters drop their req on the cycle their grant is visible.
  task automatic track(input int n_done, input int budget, output bit ok);
    int seen = 0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (send_request) sr_cycles++;
      if ($countones(grant) > 1 || (|grant && !send_request)) bad_grant++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          g_q.push_back(i);
          gcyc_q.push_back(cyc);
          gdata_q.push_back(tx_data);
          req[i] = 1'b0;
        end
        if (done[i]) begin
          d_q.push_back(i);
          seen++;
        end
      end
      if (seen >= n_done && !arb_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    req        = '0;
    req_data   = '0;
    req_parity = '0;
    tick();
    tick();
    checks++;
    if ({send_request, grant, done, arb_busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: send/grant/done/busy=%b required 0", {send_request, grant, done, arb_busy});
    end
    checks++;
    if ({tx_data, parity_enable} !== 9'h0) begin
      errors++;
      $display("FAIL reset_data: tx_data=%h parity=%b required 00/0", tx_data, parity_enable);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout_err: got %b required 0", timeout_err);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int start;
    clear_logs();
    req_data[0 +: 8] = 8'h55;
    req_parity[0]    = 1'b0;
    req              = 4'b0001;
    start            = cyc;
    track(1, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_complete: frame did not finish within budget");
    end
    checks++;
    if (pack_idx(g_q) !== 32'h1) begin
      errors++;
      $display("FAIL single_grants: got %h required 1 (requester 0 once)", pack_idx(g_q));
    end
    checks++;
    if (gcyc_q.size() != 1 || gcyc_q[0] - start != 1) begin
      errors++;
      $display("FAIL single_latency: grant cycles %p after req at %0d required +1", gcyc_q, start);
    end
    checks++;
    if (pack_bytes(rx_q) !== 32'h55) begin
      errors++;
      $display("FAIL single_rx: got %h required 55", pack_bytes(rx_q));
    end
    checks++;
    if (pack_idx(d_q) !== 32'h1) begin
      errors++;
      $display("FAIL single_done: got %h required 1", pack_idx(d_q));
    end
    checks++;
    if (arb_busy !== 1'b0 || bad_grant != 0) begin
      errors++;
      $display("FAIL single_idle: arb_busy=%b bad_grant=%0d required 0/0", arb_busy, bad_grant);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad_gap = 0;
    // Return the pointer to 0 so the sweep starts at requester 0.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    clear_logs();
    req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_parity = '0;
    req        = 4'b1111;
    track(4, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_complete: four frames did not finish within budget");
    end
    checks++;
    if (pack_idx(g_q) !== 32'h1234) begin
      errors++;
      $display("FAIL b2b_order: got %h required 1234 (requesters 0,1,2,3)", pack_idx(g_q));
    end
    checks++;
    if (pack_bytes(rx_q) !== 32'hA0A1A2A3) begin
      errors++;
      $display("FAIL b2b_rx: got %h required a0a1a2a3", pack_bytes(rx_q));
    end
    for (int i = 1; i < gcyc_q.size(); i++) begin
      if (gcyc_q[i] - gcyc_q[i-1] != GAP) bad_gap++;
    end
    checks++;
    if (bad_gap != 0 || gcyc_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_gap: grant cycles %p required spacing %0d", gcyc_q, GAP);
    end
    checks++;
    if (pack_idx(d_q) !== 32'h1234 || bad_grant != 0) begin
      errors++;
      $display("FAIL b2b_done: got %h bad_grant=%0d required 1234/0", pack_idx(d_q), bad_grant);
    end
  endtask

  task automatic test_wrap();
    bit ok1, ok2;
    clear_logs();
    req_data = {8'h04, 8'h03, 8'h02, 8'h01};
    req      = 4'b0100;
    track(1, 100, ok1);
    req      = 4'b0101;
    track(2, 200, ok2);
    checks++;
    if (!(ok1 && ok2) || pack_idx(g_q) !== 32'h313) begin
      errors++;
      $display("FAIL wrap_order: got %h ok=%b%b required 313 (2, then 0, then 2)", pack_idx(g_q), ok1, ok2);
    end
    checks++;
    if (pack_bytes(rx_q) !== 32'h030103) begin
      errors++;
      $display("FAIL wrap_rx: got %h required 030103", pack_bytes(rx_q));
    end
  endtask

  task automatic test_parity();
    bit ok;
    clear_logs();
    req_data[8 +: 8] = 8'h5A;
    req_parity       = 4'b0010;
    req              = 4'b0010;
    track(1, 100, ok);
    checks++;
    if (!ok || pack_idx(g_q) !== 32'h2) begin
      errors++;
      $display("FAIL parity_grant: got %h ok=%b required 2", pack_idx(g_q), ok);
    end
    checks++;
    if (pack_bytes(rx_q) !== 32'h5A || rxp_q.size() != 1 || rxp_q[0] !== 1'b1) begin
      errors++;
      $display("FAIL parity_rx: byte %h parity %p required 5a/1", pack_bytes(rx_q), rxp_q);
    end
    checks++;
    if (m_unstable != 0) begin
      errors++;
      $display("FAIL parity_stable: %0d busy cycles changed tx_data/parity required 0", m_unstable);
    end
    // Latched values persist after the frame until the next launch.
    checks++;
    if (tx_data !== 8'h5A || parity_enable !== 1'b1) begin
      errors++;
      $display("FAIL parity_hold: tx_data=%h parity=%b required 5a/1", tx_data, parity_enable);
    end
    req_parity = '0;
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    bit quiet = 1'b0;
    bit ok;
    logic busy_before;
    clear_logs();
    // Pointer is 2 here; requester 1 still wins after wrapping.
    req_data[8 +: 8] = 8'h3C;
    req              = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (grant[1]) begin
        got = 1'b1;
        req = '0;
        break;
      end
    end
    tick();
    tick();
    busy_before = arb_busy;
    reset_n = 1'b0;
    #1;
    checks++;
    if (!got || busy_before !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: grant seen=%b arb_busy=%b required 1/1", got, busy_before);
    end
    checks++;
    if ({send_request, grant, done, arb_busy} !== 10'b0) begin
      errors++;
      $display("FAIL rst_mid_async: send/grant/done/busy=%b required 0", {send_request, grant, done, arb_busy});
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (!tx_busy && !tx_done) begin
        quiet = 1'b1;
        break;
      end
    end
    checks++;
    if (!quiet || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: uart quiet=%b arb_busy=%b required 1/0", quiet, arb_busy);
    end
    // A reset pointer searches from 0, so requester 1 beats requester 2.
    clear_logs();
    req_data[8 +: 8]  = 8'h11;
    req_data[16 +: 8] = 8'h22;
    req               = 4'b0110;
    track(2, 200, ok);
    checks++;
    if (!ok || pack_idx(g_q) !== 32'h23) begin
      errors++;
      $display("FAIL rst_mid_ptr: got %h ok=%b required 23 (1 then 2)", pack_idx(g_q), ok);
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    clear_logs();
    uart_en = 1'b0;
    req_data[0 +: 8] = 8'h77;
    req              = 4'b0001;
    track(1, 200, ok);
    checks++;
    if (!ok || pack_idx(d_q) !== 32'h1) begin
      errors++;
      $display("FAIL tmo_done: got %h ok=%b required 1", pack_idx(d_q), ok);
    end
    checks++;
    if (sr_cycles != TIMEOUT) begin
      errors++;
      $display("FAIL tmo_len: send_request high %0d cycles required %0d", sr_cycles, TIMEOUT);
    end
    checks++;
    if (timeout_err !== 1'b1 || send_request !== 1'b0) begin
      errors++;
      $display("FAIL tmo_flag: timeout_err=%b send=%b required 1/0", timeout_err, send_request);
    end
    uart_en = 1'b1;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_parity();
    test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
